zpipe_core: RTL and testbench
=============================

Name: zpipe_core

Overview:
- Parametrised successor of the Processor-Z core: a 4-stage pipeline (Fetch, Decode, Execute, Write-back) with internal instruction RAM, register file and ALU.
- Width, memory depth and register count are parametrised.
- Adds over the current core: operand forwarding, HALT/NOP handling, start/busy/halted control, illegal-opcode detection and a retired-instruction counter.
- Sits under the test harness; instructions are loaded through the write port while idle.

Parameters:
DATA_W, 32, datapath and register width (16..32).
ADDR_W, 9, instruction RAM address width; depth = 2**ADDR_W words of 32 bits.
NREG, 8, number of architectural registers (power of two, 2..16).
CNT_W, 16, width of retired counter.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-low reset.
addr  input  ADDR_W  load address.
wr  input  1  load strobe; writes wdata to addr when idle.
wdata  input  32  instruction word to load.
start  input  1  one-cycle pulse; begin execution at PC=0 when idle.
busy  output  1  pipeline running.
halted  output  1  HALT retired; sticky until start or reset.
illegal  output  1  sticky; an unknown opcode was decoded.
valE  output  DATA_W  current Execute-stage ALU result.
retired  output  CNT_W  count of retired non-bubble instructions; wraps.
regs  output  NREG*DATA_W  flattened register file; r0 in LSBs.

Behaviour:
- Instruction format: [31:28] icode, [27:24] ifun, [23:20] rA, [19:16] rB, [15:0] valC.
  - Register index = low log2(NREG) bits of rA/rB.
  - rA = 0xF means "none" (IRMOV).
- Opcodes {icode,ifun}:
  - 0x00 NOP.
  - 0x10 IRMOV: rB <= zero-extended valC, truncated to DATA_W.
  - 0x20 ADD: rA <= rA+rB.
  - 0x21 SUB: rA <= rA-rB.
  - 0x22 AND: rA <= rA & rB.
  - 0x23 XOR: rA <= rA ^ rB.
  - 0xF0 HALT.
  - All ALU results are modulo 2**DATA_W.
  - Any other code: executed as NOP, sets illegal.
- Reset (reset=0, asynchronous):
  - PC=0; all pipeline registers become bubbles; registers=0.
  - busy=0, halted=0, illegal=0, retired=0, valE=0.
  - RAM contents are retained.
  - Reset mid-run aborts all in-flight instructions; nothing further is written.
- Idle (busy=0):
  - wr=1 writes RAM[addr] at the clock edge.
  - start=1 sets busy=1, PC=0, clears halted, illegal and retired.
  - start and wr asserted together: the write is dropped.
- Running (busy=1):
  - wr and start are ignored.
- Pipeline timing:
  - RAM read is synchronous.
  - An instruction addressed in cycle c is in Decode in c+1, Execute in c+2 and Write-back in c+3.
  - Its result is visible on regs from cycle c+4.
  - One instruction is issued per cycle; there are no stalls.
- Forwarding in Decode, in priority order:
  1. Execute-stage result (matching dst, write-enable).
  2. Write-back-stage result.
  3. Register file.
  - Back-to-back dependent instructions therefore see correct values.
  - Same-cycle register write and read returns the new value.
- HALT:
  - When HALT enters Decode, fetch stops and PC freezes.
  - The instruction already fetched behind HALT is squashed to a bubble.
  - When HALT retires from Write-back: busy=0 and halted=1 on the next edge.
- PC wrap: PC increments modulo 2**ADDR_W; running off the end wraps to 0 without a flag.
- Counter: retired increments once per non-bubble instruction leaving Write-back, including NOP, HALT and illegal codes.
- valE: combinational ALU output of the Execute stage; 0 when Execute holds a bubble.

Test Plan:
1. Load IRMOV r0..r7 with 0x80..0x87, then 0x20010000, 0x21230000, 0x22450000, 0x23670000, then HALT; pulse start.
   -> r0=0x101, r2=0xFFFFFFFF, r4=0x84, r6=0x01; halted=1, busy=0, retired=13, illegal=0.
2. Forwarding: IRMOV r1,5; IRMOV r2,3; ADD r1,r2; ADD r1,r1; HALT, all back to back.
   -> r1=0x10, r2=3; no stalls (busy high exactly 8 cycles after start).
3. Opcode 0x57000000 mid-program, then HALT.
   -> illegal=1, no register changes from it; retired counts it; a later start clears illegal.
4. Assert reset low for 3 cycles mid-run during instruction 6 of scenario 1.
   -> all registers 0, busy=0, retired=0 immediately (async).
   -> A subsequent start with no reload reproduces the scenario 1 results (RAM retained).
5. Assert wr with wdata=0 at addr 0 while busy.
   -> RAM unchanged; the program completes as in scenario 1.
   -> Start and wr together when idle: the write is dropped.
6. DATA_W=16, ADDR_W=4 build: IRMOV r0,0xFFFF; IRMOV r1,1; ADD r0,r1; HALT.
   -> r0=0x0000.
   -> A program with no HALT wraps PC 15->0 and busy stays 1.

Source files
------------

// File: rtl/zpipe_core_if.sv
// Load/control/status bundle between the test harness and zpipe_core.
// The harness is the master; the core exposes its state through the slave side.
interface zpipe_core_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int NREG   = 8,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0]      addr;
  logic                   wr;
  logic [31:0]            wdata;
  logic                   start;
  logic                   busy;
  logic                   halted;
  logic                   illegal;
  logic [DATA_W-1:0]      valE;
  logic [CNT_W-1:0]       retired;
  logic [NREG*DATA_W-1:0] regs;

  modport master (
    output addr, wr, wdata, start,
    input  busy, halted, illegal, valE, retired, regs
  );

  modport slave (
    input  addr, wr, wdata, start,
    output busy, halted, illegal, valE, retired, regs
  );
endinterface

// File: rtl/zpipe_core.sv
// Four-stage Fetch/Decode/Execute/Write-back core with instruction RAM,
// register file, operand forwarding, HALT squash and a retired counter.
module zpipe_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int NREG   = 8,
  parameter int CNT_W  = 16
) (
  input  logic        clock,
  input  logic        reset,
  zpipe_core_if.slave bus
);

  localparam int RI_W  = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_XOR} op_e;

  function automatic logic [DATA_W-1:0] alu_f(input op_e op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return b;
    endcase
  endfunction

  logic [31:0]        ram [DEPTH];
  logic [DATA_W-1:0]  rf_q [NREG];

  logic               busy_q, halted_q, illegal_q, stop_q;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]   retired_q;
  logic               fetch_en;

  logic               vld_p1_q, vld_p2_q, vld_p3_q;
  logic               halt_p2_q, halt_p3_q;
  logic [31:0]        ir_p1_q;
  op_e                op_p2_q;
  logic [DATA_W-1:0]  a_p2_q, b_p2_q, res_p3_q;
  logic [RI_W-1:0]    dst_p2_q, dst_p3_q;
  logic               we_p2_q, we_p3_q;

  logic [3:0]         ra_f, rb_f;
  logic [RI_W-1:0]    ra, rb;
  logic [DATA_W-1:0]  imm, opa, opb, alu_res;
  logic [DATA_W-1:0]  dec_a, dec_b;
  logic [RI_W-1:0]    dec_dst;
  op_e                dec_op;
  logic               dec_we, dec_halt, dec_ill;
  logic               unused_fields;

  // ---- Decode: field split, forwarding (Execute > Write-back > file)
  assign ra_f          = ir_p1_q[23:20];
  assign rb_f          = ir_p1_q[19:16];
  assign ra            = ra_f[RI_W-1:0];
  assign rb            = rb_f[RI_W-1:0];
  assign unused_fields = ^{ra_f, rb_f};

  always_comb begin
    imm       = '0;
    imm[15:0] = ir_p1_q[15:0];
    opa = rf_q[ra];
    if (vld_p3_q && we_p3_q && dst_p3_q == ra) opa = res_p3_q;
    if (vld_p2_q && we_p2_q && dst_p2_q == ra) opa = alu_res;
    opb = rf_q[rb];
    if (vld_p3_q && we_p3_q && dst_p3_q == rb) opb = res_p3_q;
    if (vld_p2_q && we_p2_q && dst_p2_q == rb) opb = alu_res;
  end

  always_comb begin
    dec_a    = '0;
    dec_b    = '0;
    dec_dst  = ra;
    dec_op   = OP_MOV;
    dec_we   = 1'b0;
    dec_halt = 1'b0;
    dec_ill  = 1'b0;
    case (ir_p1_q[31:24])
      8'h00: ;
      8'h10: begin dec_we = 1'b1; dec_dst = rb; dec_b = imm; end
      8'h20: begin dec_we = 1'b1; dec_op = OP_ADD; dec_a = opa; dec_b = opb; end
      8'h21: begin dec_we = 1'b1; dec_op = OP_SUB; dec_a = opa; dec_b = opb; end
      8'h22: begin dec_we = 1'b1; dec_op = OP_AND; dec_a = opa; dec_b = opb; end
      8'h23: begin dec_we = 1'b1; dec_op = OP_XOR; dec_a = opa; dec_b = opb; end
      8'hF0: dec_halt = 1'b1;
      default: dec_ill = 1'b1;
    endcase
  end

  // ---- Execute: bubbles present zero on valE
  assign alu_res = vld_p2_q ? alu_f(op_p2_q, a_p2_q, b_p2_q) : '0;

  // A HALT sitting in Decode squashes the fetch happening alongside it
  assign fetch_en = !stop_q && !(vld_p1_q && dec_halt);
  assign pc_d     = fetch_en ? pc_q + ADDR_W'(1) : pc_q;

  // ---- Control, register file and stage valids
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      stop_q    <= 1'b0;
      pc_q      <= '0;
      retired_q <= '0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      halt_p2_q <= 1'b0;
      halt_p3_q <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (!busy_q) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      halt_p2_q <= 1'b0;
      halt_p3_q <= 1'b0;
      if (bus.start) begin
        busy_q    <= 1'b1;
        pc_q      <= '0;
        halted_q  <= 1'b0;
        illegal_q <= 1'b0;
        retired_q <= '0;
        stop_q    <= 1'b0;
      end
    end else begin
      vld_p1_q  <= fetch_en;
      pc_q      <= pc_d;
      vld_p2_q  <= vld_p1_q;
      halt_p2_q <= vld_p1_q && dec_halt;
      if (vld_p1_q && dec_halt) stop_q    <= 1'b1;
      if (vld_p1_q && dec_ill)  illegal_q <= 1'b1;
      vld_p3_q  <= vld_p2_q;
      halt_p3_q <= halt_p2_q;
      if (vld_p3_q) begin
        retired_q <= retired_q + CNT_W'(1);
        if (we_p3_q) rf_q[dst_p3_q] <= res_p3_q;
        if (halt_p3_q) begin
          busy_q   <= 1'b0;
          halted_q <= 1'b1;
        end
      end
    end
  end

  // ---- Fetch RAM and stage data (qualified by the valids above)
  always_ff @(posedge clock) begin
    if (bus.wr && !busy_q && !bus.start) ram[bus.addr] <= bus.wdata;
    ir_p1_q  <= ram[pc_q];
    a_p2_q   <= dec_a;
    b_p2_q   <= dec_b;
    op_p2_q  <= dec_op;
    dst_p2_q <= dec_dst;
    we_p2_q  <= dec_we;
    res_p3_q <= alu_res;
    dst_p3_q <= dst_p2_q;
    we_p3_q  <= we_p2_q;
  end

  assign bus.busy    = busy_q;
  assign bus.halted  = halted_q;
  assign bus.illegal = illegal_q;
  assign bus.valE    = alu_res;
  assign bus.retired = retired_q;

  for (genvar g = 0; g < NREG; g++) begin : g_regs
    assign bus.regs[g*DATA_W +: DATA_W] = rf_q[g];
  end

endmodule

// File: tb/tb_zpipe_core.sv
// Directed bench for zpipe_core: a 32-bit/512-word build and a 16-bit/16-word
// build side by side, with hand-computed register and status expectations.
module tb_zpipe_core;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  localparam logic [31:0] HALT = 32'hF000_0000;

  zpipe_core_if #(.DATA_W(32), .ADDR_W(9), .NREG(8), .CNT_W(16)) bus ();
  zpipe_core_if #(.DATA_W(16), .ADDR_W(4), .NREG(8), .CNT_W(16)) b16 ();

  zpipe_core #(.DATA_W(32), .ADDR_W(9), .NREG(8), .CNT_W(16)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  zpipe_core #(.DATA_W(16), .ADDR_W(4), .NREG(8), .CNT_W(16)) u_dut16 (
    .clock (clock),
    .reset (reset),
    .bus   (b16)
  );

  logic [31:0] r32 [8];
  logic [15:0] r16 [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      r32[i] = bus.regs[i*32 +: 32];
      r16[i] = b16.regs[i*16 +: 16];
    end
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_irmov(input logic [3:0] rb, input logic [15:0] v);
    return {8'h10, 4'hF, rb, v};
  endfunction

  function automatic logic [31:0] f_alu(input logic [3:0] fn, input logic [3:0] ra,
                                        input logic [3:0] rb);
    return {4'h2, fn, ra, rb, 16'h0000};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int a, input logic [31:0] w);
    bus.addr  = a[8:0];
    bus.wdata = w;
    bus.wr    = 1'b1;
    tick();
    bus.wr    = 1'b0;
  endtask

  task automatic load16(input int a, input logic [31:0] w);
    b16.addr  = a[3:0];
    b16.wdata = w;
    b16.wr    = 1'b1;
    tick();
    b16.wr    = 1'b0;
  endtask

  task automatic go();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic go16();
    b16.start = 1'b1;
    tick();
    b16.start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy !== 1'b0 && cyc < 200) begin
      tick();
      cyc++;
    end
    check_eq("idle_timeout", bus.busy, 0);
  endtask

  task automatic wait_idle16(output int cyc);
    cyc = 0;
    while (b16.busy !== 1'b0 && cyc < 200) begin
      tick();
      cyc++;
    end
    check_eq("idle16_timeout", b16.busy, 0);
  endtask

  task automatic load_s1();
    for (int i = 0; i < 8; i++) load(i, f_irmov(i[3:0], 16'h0080 + i[15:0]));
    load(8,  32'h2001_0000);
    load(9,  32'h2123_0000);
    load(10, 32'h2245_0000);
    load(11, 32'h2367_0000);
    load(12, HALT);
  endtask

  task automatic check_s1(input string tag);
    check_eq({tag, "_r0"}, r32[0], 32'h0000_0101);
    check_eq({tag, "_r2"}, r32[2], 32'hFFFF_FFFF);
    check_eq({tag, "_r4"}, r32[4], 32'h0000_0084);
    check_eq({tag, "_r6"}, r32[6], 32'h0000_0001);
    check_eq({tag, "_r7"}, r32[7], 32'h0000_0087);
    check_eq({tag, "_halted"}, bus.halted, 1);
    check_eq({tag, "_busy"}, bus.busy, 0);
    check_eq({tag, "_retired"}, bus.retired, 13);
    check_eq({tag, "_illegal"}, bus.illegal, 0);
  endtask

  initial begin
    int cyc;
    reset     = 1'b0;
    bus.addr  = '0; bus.wr = 1'b0; bus.wdata = '0; bus.start = 1'b0;
    b16.addr  = '0; b16.wr = 1'b0; b16.wdata = '0; b16.start = 1'b0;
    repeat (3) tick();

    check_eq("rst_busy",    bus.busy,    0);
    check_eq("rst_halted",  bus.halted,  0);
    check_eq("rst_illegal", bus.illegal, 0);
    check_eq("rst_retired", bus.retired, 0);
    check_eq("rst_valE",    bus.valE,    0);
    check_eq("rst_regs",    |bus.regs,   0);
    reset = 1'b1;
    tick();

    // Scenario 1: full ALU program
    load_s1();
    go();
    check_eq("s1_busy_after_start", bus.busy, 1);
    repeat (10) tick();
    check_eq("s1_valE_add", bus.valE, 32'h0000_0101);
    wait_idle(cyc);
    check_s1("s1");

    // Scenario 2: back-to-back dependencies, no stalls
    load(0, f_irmov(4'd1, 16'd5));
    load(1, f_irmov(4'd2, 16'd3));
    load(2, f_alu(4'h0, 4'd1, 4'd2));
    load(3, f_alu(4'h0, 4'd1, 4'd1));
    load(4, HALT);
    go();
    wait_idle(cyc);
    check_eq("s2_busy_cycles", cyc, 8);
    check_eq("s2_r1", r32[1], 32'h10);
    check_eq("s2_r2", r32[2], 32'h3);
    check_eq("s2_retired", bus.retired, 5);

    // Scenario 3: illegal opcode behaves as NOP but is flagged and counted
    load(0, f_irmov(4'd3, 16'h0033));
    load(1, 32'h5700_0000);
    load(2, HALT);
    go();
    wait_idle(cyc);
    check_eq("s3_illegal", bus.illegal, 1);
    check_eq("s3_r0_kept", r32[0], 32'h0000_0101);
    check_eq("s3_r3", r32[3], 32'h33);
    check_eq("s3_retired", bus.retired, 3);
    check_eq("s3_halted", bus.halted, 1);
    go();
    check_eq("s3_start_clears_illegal", bus.illegal, 0);
    check_eq("s3_start_clears_halted", bus.halted, 0);
    wait_idle(cyc);

    // Scenario 4: asynchronous reset mid-run, then rerun without reload
    load_s1();
    go();
    repeat (6) tick();
    #2 reset = 1'b0;
    #1;
    check_eq("s4_regs_cleared", |bus.regs, 0);
    check_eq("s4_busy_cleared", bus.busy, 0);
    check_eq("s4_retired_cleared", bus.retired, 0);
    check_eq("s4_valE_cleared", bus.valE, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    tick();
    go();
    wait_idle(cyc);
    check_s1("s4");

    // Scenario 5: writes and start ignored while busy; start+wr drops the write
    go();
    repeat (2) tick();
    bus.addr = '0; bus.wdata = 32'h0; bus.wr = 1'b1; bus.start = 1'b1;
    repeat (3) tick();
    bus.wr = 1'b0; bus.start = 1'b0;
    wait_idle(cyc);
    check_s1("s5");
    go();
    wait_idle(cyc);
    check_eq("s5_ram_kept_r0", r32[0], 32'h0000_0101);
    bus.addr = '0; bus.wdata = HALT; bus.wr = 1'b1; bus.start = 1'b1;
    tick();
    bus.wr = 1'b0; bus.start = 1'b0;
    wait_idle(cyc);
    check_eq("s5_startwr_retired", bus.retired, 13);
    check_eq("s5_startwr_r0", r32[0], 32'h0000_0101);

    // Scenario 6: 16-bit build, wraparound arithmetic and PC wrap
    load16(0, f_irmov(4'd0, 16'hFFFF));
    load16(1, f_irmov(4'd1, 16'h0001));
    load16(2, 32'h2001_0000);
    load16(3, HALT);
    go16();
    wait_idle16(cyc);
    check_eq("s6_r0_wrap", r16[0], 16'h0000);
    check_eq("s6_r1", r16[1], 16'h0001);
    check_eq("s6_retired", b16.retired, 4);
    check_eq("s6_halted", b16.halted, 1);
    for (int i = 0; i < 16; i++) load16(i, f_irmov(4'd2, 16'h0100 + i[15:0]));
    go16();
    repeat (17) tick();
    check_eq("s6_valE_addr15", b16.valE, 16'h010F);
    tick();
    check_eq("s6_valE_pc_wrapped", b16.valE, 16'h0100);
    repeat (30) tick();
    check_eq("s6_busy_no_halt", b16.busy, 1);
    check_eq("s6_halted_no_halt", b16.halted, 0);
    #2 reset = 1'b0;
    #1;
    check_eq("s6_reset_busy", b16.busy, 0);
    tick();
    reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
